// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b code tables, comma constants and the legal-K check for enc_8b10b.
package enc8b10b_pkg;

    // 5b/6b codes (abcdei) for running disparity negative, indexed by x = EDCBA.
    localparam logic [5:0] CODE6_RDN [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    // Bit x set when the 6b code for D.x is balanced. D.7 is left clear so
    // that it is inverted at RD+ and flips the disparity like an unbalanced code.
    localparam logic [31:0] BALANCED6 = 32'b0001_0110_0111_1110_0111_1110_0110_1000;

    // K28 has its own 6b code, different from D.28.
    localparam logic [5:0] K28_6B_RDN = 6'b001111;
    localparam logic [5:0] K28_6B_RDP = 6'b110000;

    // 3b/4b data codes (fghj) for rd6 negative, indexed by y = HGF.
    // Entry 7 is the primary P7 code; the alternate A7 is chosen separately.
    localparam logic [3:0] D4_RDN [0:7] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    // Bit y set when the data 4b code is inverted at rd6 positive (y = 0, 3, 4, 7).
    localparam logic [7:0] D4_COMPL = 8'b1001_1001;

    // 3b/4b control codes (fghj) for rd6 negative; every entry is inverted at rd6 positive.
    localparam logic [3:0] K4_RDN [0:7] = '{
        4'b1011, 4'b0110, 4'b1010, 4'b1100,
        4'b1101, 4'b0101, 4'b1001, 4'b0111
    };

    // Bit y set when the 4b code for that y is unbalanced and flips the disparity.
    localparam logic [7:0] UNBAL4 = 8'b1001_0001;

    // Complete K28.5 comma groups emitted when no byte is offered.
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // Legal control codes: K28.0-K28.7 plus K23.7, K27.7, K29.7 and K30.7.
    function automatic logic isLegalK(input logic [4:0] x, input logic [2:0] y);
        logic legal;
        legal = 1'b0;
        if (x == 5'd28) begin
            legal = 1'b1;
        end else if (y == 3'd7) begin
            legal = (x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30);
        end
        return legal;
    endfunction

endpackage

// File: rtl/enc_5b6b_3b4b_lut.sv
// Combinational 8b/10b code lookup: one byte in, one 10-bit group and the next RD out.
module enc_5b6b_3b4b_lut
    import enc8b10b_pkg::*;
(
    input  logic [4:0] x,
    input  logic [2:0] y,
    input  logic       K,
    input  logic       rd_in,
    output logic [9:0] code10,
    output logic       rd_out,
    output logic       k_illegal
);

    logic       legalK;
    logic       useK;
    logic       unbal6;
    logic       rd6;
    logic       useAlt7;
    logic [5:0] code6;
    logic [3:0] code4;

    // Encode the 6b sub-block at rd_in, then the 4b sub-block at the disparity it leaves.
    // An illegal control request falls back to the data code but still forces A7 on y = 7.
    always_comb begin
        legalK    = isLegalK(x, y);
        useK      = K && legalK;
        k_illegal = K && !legalK;
        unbal6    = !BALANCED6[x];
        rd6       = rd_in;
        code6     = CODE6_RDN[x];
        useAlt7   = 1'b0;
        code4     = D4_RDN[y];

        if (useK && (x == 5'd28)) begin
            code6 = rd_in ? K28_6B_RDP : K28_6B_RDN;
            rd6   = ~rd_in;
        end else begin
            code6 = (rd_in && unbal6) ? ~CODE6_RDN[x] : CODE6_RDN[x];
            rd6   = rd_in ^ unbal6;
        end

        if (useK) begin
            code4 = rd6 ? ~K4_RDN[y] : K4_RDN[y];
        end else if (y == 3'd7) begin
            useAlt7 = K
                   || (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)))
                   || ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
            if (useAlt7) begin
                code4 = rd6 ? 4'b1000 : 4'b0111;
            end else begin
                code4 = rd6 ? 4'b0001 : 4'b1110;
            end
        end else begin
            code4 = (rd6 && D4_COMPL[y]) ? ~D4_RDN[y] : D4_RDN[y];
        end

        rd_out = rd6 ^ UNBAL4[y];
        code10 = {code6, code4};
    end

endmodule

// File: rtl/enc_8b10b.sv
// 8b/10b encoder: registered code group, running disparity tracking and optional comma insertion.
module enc_8b10b
    import enc8b10b_pkg::*;
#(
    parameter bit IDLE_INSERT = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    input  logic       control_in,
    output logic [9:0] data_10b,
    output logic       valid_out,
    output logic       k_err,
    output logic       rd
);

    logic [9:0] data_q;
    logic [9:0] data_d;
    logic       valid_q;
    logic       valid_d;
    logic       kerr_q;
    logic       kerr_d;
    logic       rd_q;
    logic       rd_d;

    logic [9:0] lutCode;
    logic       lutRd;
    logic       lutKIllegal;

    enc_5b6b_3b4b_lut uLut (
        .x         (data_in[4:0]),
        .y         (data_in[7:5]),
        .K         (control_in),
        .rd_in     (rd_q),
        .code10    (lutCode),
        .rd_out    (lutRd),
        .k_illegal (lutKIllegal)
    );

    // Choose the next group: the encoded byte, an idle comma, or a hold of the last group.
    always_comb begin
        data_d  = data_q;
        rd_d    = rd_q;
        valid_d = 1'b0;
        kerr_d  = 1'b0;
        if (valid_in) begin
            data_d  = lutCode;
            rd_d    = lutRd;
            valid_d = 1'b1;
            kerr_d  = lutKIllegal;
        end else if (IDLE_INSERT) begin
            data_d  = rd_q ? K28_5_RDP : K28_5_RDN;
            rd_d    = ~rd_q;
            valid_d = 1'b1;
        end
    end

    // Register the group and disparity; reset drops any group in flight and returns to RD-.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            kerr_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            kerr_q  <= kerr_d;
            rd_q    <= rd_d;
        end
    end

    assign data_10b  = data_q;
    assign valid_out = valid_q;
    assign k_err     = kerr_q;
    assign rd        = rd_q;

endmodule

// File: doc/enc_8b10b.md
Name: enc_8b10b

Overview:
- 8b/10b encoder with running disparity (RD) tracking, the transmit counterpart of the receive-side decoder in the 1G Ethernet PCS.
- Accepts one byte plus a control flag per cycle and produces one registered 10-bit code group with one cycle of latency.
- Optionally inserts /K28.5/ commas when no byte is offered.
- Output bit order matches the decoder: data_10b[9:4] = abcdei (a at bit 9), data_10b[3:0] = fghj (f at bit 3).

Parameters:
- IDLE_INSERT, 1, when 1 the block emits K28.5 on cycles with valid_in=0; when 0 it holds the output and RD.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- valid_in  input  1  data_in and control_in are valid this cycle.
- data_in  input  8  byte HGFEDCBA: [7:5]=y (HGF), [4:0]=x (EDCBA).
- control_in  input  1  1 = encode as K.x.y, 0 = encode as D.x.y.
- data_10b  output  10  registered code group abcdeifghj.
- valid_out  output  1  data_10b holds a new code group this cycle.
- k_err  output  1  the previous accepted input requested an illegal K code.
- rd  output  1  current running disparity after the last emitted group (0 = RD-, 1 = RD+).

Behaviour:
- Reset (synchronous, active-high):
  - rd=0 (RD-), data_10b=0, valid_out=0, k_err=0.
  - Reset asserted mid-stream discards the in-flight group.
  - The first group after reset is encoded at RD-.
- Latency: inputs sampled at edge N appear on data_10b and valid_out after edge N; rd and k_err update on the same edge.
- 5b/6b sub-block:
  - Standard table selected by the RD in effect at that edge.
  - Unbalanced codes (4 or 2 ones) flip RD; balanced codes keep it.
  - D.7 is treated as unbalanced: 111000 at RD-, 000111 at RD+.
  - K28 uses 001111 at RD- and 110000 at RD+.
- 3b/4b sub-block:
  - Selected by RD after the 6b sub-block (rd6), using the standard table.
  - D.x.7 uses the alternate code A7 (0111 at rd6=-, 1000 at rd6=+) when:
    - rd6=- and x is 17, 18 or 20; or
    - rd6=+ and x is 11, 13 or 14; or
    - control_in=1.
  - Otherwise D.x.7 uses the primary code P7 (1110 / 0001).
  - K28.y uses the K 3b/4b column (K28.1, K28.2, K28.5, K28.6 invert relative to D).
- Next RD is the RD after the 4b sub-block; it is registered into rd.
- Legal K codes are K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7.
- control_in=1 with any other byte:
  - The byte is encoded as D.x.y.
  - k_err=1 for that one output cycle.
  - RD updates normally.
- valid_in=0:
  - IDLE_INSERT=1: emit K28.5 at the current RD (001111 1010 at RD-, 110000 0101 at RD+); valid_out=1, k_err=0, RD flips.
  - IDLE_INSERT=0: data_10b holds its value; valid_out=0, k_err=0, rd unchanged.
- No back-pressure: one group per cycle, with no stall input.

Decomposition:
- Package enc8b10b_pkg holds:
  - 5b/6b RD- table (32 x 6b) and the per-entry balanced flag;
  - 3b/4b D and K tables;
  - localparams K28_5_RDN = 10'b0011111010 and K28_5_RDP = 10'b1100000101;
  - the legal-K list.
- One combinational sub-module, enc_5b6b_3b4b_lut:
  - inputs: x, y, K, rd_in;
  - outputs: code10, rd_out, k_illegal.
- The top level holds the RD register, output registers and idle mux.

Test Plan:
- Reset, then D.0.0 (data_in=0x00, control_in=0) -> data_10b=1001110100, rd=0.
- K28.5 (0xBC, control_in=1) twice from RD- -> 0011111010 with rd=1, then 1100000101 with rd=0, k_err=0.
- D.21.5 (0xB5) at RD- -> 1010101010, rd stays 0.
- D.17.7 (0xF1) at RD- -> 1000110111 (A7), rd=1; then D.11.7 (0xEB) at RD+ -> 1101001000 (A7), rd=0.
- control_in=1 with 0x00 -> k_err=1 for one cycle, data_10b=1001110100; next valid K28.0 (0x1C) -> k_err=0.
- IDLE_INSERT=1 with valid_in low for 4 cycles from RD- -> K28.5 alternating RD-/RD+ and rd toggling.
- IDLE_INSERT=0 with valid_in low -> valid_out=0 and data_10b and rd frozen.
- Reset pulsed after a group that leaves rd=1 -> rd=0 on the next edge, and the next D.0.0 encodes as 1001110100.
